// File: rtl/servo_pwm_posicionador.sv
// rtl/servo_pwm_posicionador.sv - servo PWM generator with saturating position index and optional slew
// Width changes are applied only at the period boundary so an in-flight pulse is never cut or stretched.
module servo_pwm_posicionador #(
  parameter int PERIOD_CYCLES = 1_000_000,
  parameter int POS_BITS      = 2,
  parameter int MIN_PULSE     = 50_000,
  parameter int STEP_PULSE    = 16_667,
  parameter int RAMP_INC      = 0
) (
  input  logic                clock,
  input  logic                zera,
  input  logic                set_pos,
  input  logic [POS_BITS-1:0] pos_inicial,
  input  logic                direita,
  input  logic                esquerda,
  output logic                pwm,
  output logic [POS_BITS-1:0] pos,
  output logic                ocupado,
  output logic                fim_periodo,
  output logic                db_pwm
);

  localparam int CNT_W = $clog2(PERIOD_CYCLES + 1);
  localparam logic [CNT_W-1:0]    LAST    = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0]    MIN_W   = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0]    STEP_W  = CNT_W'(STEP_PULSE);
  localparam logic [CNT_W-1:0]    RAMP_W  = CNT_W'(RAMP_INC);
  localparam logic [POS_BITS-1:0] POS_MAX = '1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] largura;
  logic [CNT_W-1:0] alvo;
  logic [CNT_W-1:0] prox_largura;
  logic [CNT_W-1:0] diff;
  logic             dir_d, esq_d;
  logic             dir_e, esq_e;
  logic             step_up, step_dn;

  assign dir_e   = direita & ~dir_d;
  assign esq_e   = esquerda & ~esq_d;
  // Simultaneous opposite edges cancel; saturation blocks the step at either end.
  assign step_up = dir_e & ~esq_e & (pos != POS_MAX);
  assign step_dn = esq_e & ~dir_e & (pos != '0);

  assign alvo        = MIN_W + CNT_W'(pos) * STEP_W;
  assign fim_periodo = (cnt == LAST);
  assign ocupado     = (largura != alvo);
  assign db_pwm      = pwm;

  always_comb begin
    prox_largura = alvo;
    diff         = '0;
    if (RAMP_INC != 0) begin
      if (alvo > largura) begin
        diff         = alvo - largura;
        prox_largura = (diff > RAMP_W) ? largura + RAMP_W : alvo;
      end else begin
        diff         = largura - alvo;
        prox_largura = (diff > RAMP_W) ? largura - RAMP_W : alvo;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (zera) begin
      cnt     <= '0;
      pos     <= '0;
      largura <= MIN_W;
      dir_d   <= 1'b0;
      esq_d   <= 1'b0;
      pwm     <= 1'b0;
    end else begin
      pwm   <= (cnt < largura);
      dir_d <= direita;
      esq_d <= esquerda;
      if (fim_periodo) begin
        cnt     <= '0;
        largura <= prox_largura;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (set_pos)
        pos <= pos_inicial;
      else if (step_up)
        pos <= pos + 1'b1;
      else if (step_dn)
        pos <= pos - 1'b1;
    end
  end

endmodule

// File: tb/tb_servo_pwm_posicionador.sv
// tb/tb_servo_pwm_posicionador.sv - random-stimulus bench for servo_pwm_posicionador, direct and slewed units
module tb_servo_pwm_posicionador;

  localparam int P    = 1000;
  localparam int MINP = 100;
  localparam int STEP = 50;

  logic       clock = 1'b0;
  logic       zera, set_pos, direita, esquerda;
  logic [1:0] pos_inicial;
  logic       pwm_o[2], ocup_o[2], fim_o[2], db_o[2];
  logic [1:0] pos_o[2];

  always #5 clock = ~clock;

  servo_pwm_posicionador #(.PERIOD_CYCLES(P), .POS_BITS(2), .MIN_PULSE(MINP),
                           .STEP_PULSE(STEP), .RAMP_INC(0)) dut_direto (
    .clock(clock), .zera(zera), .set_pos(set_pos), .pos_inicial(pos_inicial),
    .direita(direita), .esquerda(esquerda), .pwm(pwm_o[0]), .pos(pos_o[0]),
    .ocupado(ocup_o[0]), .fim_periodo(fim_o[0]), .db_pwm(db_o[0]));

  servo_pwm_posicionador #(.PERIOD_CYCLES(P), .POS_BITS(2), .MIN_PULSE(MINP),
                           .STEP_PULSE(STEP), .RAMP_INC(20)) dut_rampa (
    .clock(clock), .zera(zera), .set_pos(set_pos), .pos_inicial(pos_inicial),
    .direita(direita), .esquerda(esquerda), .pwm(pwm_o[1]), .pos(pos_o[1]),
    .ocupado(ocup_o[1]), .fim_periodo(fim_o[1]), .db_pwm(db_o[1]));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int alvo_of(input int p);
    return MINP + p * STEP;
  endfunction

  function automatic int ramp_of(input int u);
    return (u == 1) ? 20 : 0;
  endfunction

  function automatic int next_w(input int w, input int a, input int r);
    if (r == 0) return a;
    if (a > w) return (a - w > r) ? w + r : a;
    return (w - a > r) ? w - r : a;
  endfunction

  // Reference: position from button semantics, width from per-period target/slew arithmetic.
  int m_pos;
  bit pd, pe;

  int hi[2], hidb[2], exp_cur[2], exp_next[2], since[2];
  bit armed[2], fim_prev[2], had_fim[2];
  bit zera_prev = 1'b0;

  always @(negedge clock) begin
    for (int u = 0; u < 2; u++) begin
      if (zera) begin
        if (zera_prev) begin
          check("rst_pwm", pwm_o[u], 0);
          check("rst_pos", pos_o[u], 0);
          check("rst_ocupado", ocup_o[u], 0);
          check("rst_fim", fim_o[u], 0);
        end
        hi[u] = 0; hidb[u] = 0; exp_cur[u] = MINP; exp_next[u] = MINP;
        armed[u] = 0; fim_prev[u] = 0; had_fim[u] = 0; since[u] = 0;
      end else begin
        hi[u]   += int'(pwm_o[u]);
        hidb[u] += int'(db_o[u]);
        since[u]++;
        if (fim_prev[u]) begin
          if (armed[u]) begin
            check(u == 0 ? "width_direto" : "width_rampa", hi[u], exp_cur[u]);
            check("db_width", hidb[u], exp_cur[u]);
          end
          armed[u] = 1; exp_cur[u] = exp_next[u]; hi[u] = 0; hidb[u] = 0;
        end
        if (fim_o[u]) begin
          if (had_fim[u]) check("fim_interval", since[u], P);
          had_fim[u] = 1; since[u] = 0;
          check("pos", pos_o[u], m_pos);
          check("ocupado", ocup_o[u], int'(exp_cur[u] != alvo_of(m_pos)));
          exp_next[u] = next_w(exp_cur[u], alvo_of(m_pos), ramp_of(u));
        end
        fim_prev[u] = fim_o[u];
      end
    end
    zera_prev = zera;
  end

  task automatic wait_fim();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!fim_o[0] && n < 3000);
    check("fim_seen", fim_o[0], 1);
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic op(input bit s, input int pi, input bit d, input bit e, input int hold);
    bit ed, ee;
    @(posedge clock); #1;
    set_pos = s; pos_inicial = 2'(pi); direita = d; esquerda = e;
    ed = d && !pd;
    ee = e && !pe;
    if (s) m_pos = pi;
    else if (ed && ee) begin end
    else if (ed && m_pos < 3) m_pos++;
    else if (ee && m_pos > 0) m_pos--;
    pd = d; pe = e;
    repeat (hold) @(posedge clock);
    #1;
    set_pos = 0; direita = 0; esquerda = 0;
    pd = 0; pe = 0;
  endtask

  initial begin
    zera = 1; set_pos = 0; pos_inicial = 0; direita = 0; esquerda = 0;
    m_pos = 0; pd = 0; pe = 0;
    repeat (5) @(posedge clock);
    #1 zera = 0;
    repeat (3) wait_fim();

    for (int i = 0; i < 3; i++) begin
      wait_fim(); gap($urandom_range(50, 300)); op(0, 0, 1, 0, 20);
    end
    repeat (2) wait_fim();
    for (int i = 0; i < 2; i++) begin
      wait_fim(); gap($urandom_range(50, 300)); op(0, 0, 1, 0, 20);
    end
    for (int i = 0; i < 5; i++) begin
      wait_fim(); gap($urandom_range(50, 300)); op(0, 0, 0, 1, 20);
    end
    repeat (2) wait_fim();

    wait_fim(); gap(500); op(1, 2, 1, 0, 20);
    repeat (2) wait_fim();
    wait_fim(); gap($urandom_range(50, 300)); op(0, 0, 1, 1, 20);
    repeat (2) wait_fim();

    for (int i = 0; i < 20; i++) begin
      wait_fim();
      repeat (1 + $urandom_range(1)) begin
        gap($urandom_range(50, 300));
        op($urandom_range(3) == 0, $urandom_range(3), 1'($urandom_range(1)),
           1'($urandom_range(1)), $urandom_range(1, 20));
      end
    end

    wait_fim(); gap(100); op(1, 0, 0, 0, 5);
    repeat (9) wait_fim();
    wait_fim(); gap(100); op(1, 3, 0, 0, 5);
    repeat (4) wait_fim();
    gap(300);
    @(posedge clock); #1 zera = 1; m_pos = 0;
    repeat (3) @(posedge clock);
    #1 zera = 0;
    repeat (3) wait_fim();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
